// File: rtl/insn_encode.sv
// insn_encode: assembles RV32I instruction words from decoded field bundles,
// flags unrepresentable immediates, and buffers results in a 2-entry FIFO.
module insn_encode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  opcode,
    input  logic [3:0]  alu_op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] insn,
    output logic        err,
    output logic [15:0] insn_count,
    output logic [15:0] err_count
);
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_STORE = 5'b10000;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b11011;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2:0]  f3;
    logic        i_fit, b_fit, j_fit;
    logic [31:0] insn_p0;
    logic        err_p0;
    logic        vld_p0;
    logic        pop;

    assign f3    = alu_op[2:0];
    // A field fits when every bit above its sign bit matches the sign bit.
    assign i_fit = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_fit = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign j_fit = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

    // Stage p0: combinational encode of the incoming bundle
    always_comb begin
        insn_p0 = {25'b0, opcode, 2'b11};
        err_p0  = 1'b1;
        case (opcode)
            OP_R: begin
                insn_p0 = {1'b0, alu_op[3], 5'b0, rs2, rs1, f3, rd, opcode, 2'b11};
                err_p0  = 1'b0;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                if (opcode == OP_IMM && (f3 == 3'b001 || f3 == 3'b101)) begin
                    insn_p0 = {1'b0, alu_op[3], 5'b0, imm[4:0], rs1, f3, rd, opcode, 2'b11};
                    err_p0  = |imm[31:5];
                end else begin
                    insn_p0 = {imm[11:0], rs1, (opcode == OP_JALR) ? 3'b000 : f3,
                               rd, opcode, 2'b11};
                    err_p0  = ~i_fit;
                end
            end
            OP_STORE: begin
                insn_p0 = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode, 2'b11};
                err_p0  = ~i_fit;
            end
            OP_BR: begin
                insn_p0 = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode, 2'b11};
                err_p0  = ~b_fit;
            end
            OP_LUI, OP_AUIPC: begin
                insn_p0 = {imm[31:12], rd, opcode, 2'b11};
                err_p0  = |imm[11:0];
            end
            OP_JAL: begin
                insn_p0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
                err_p0  = ~j_fit;
            end
            default: begin
                insn_p0 = {25'b0, opcode, 2'b11};
                err_p0  = 1'b1;
            end
        endcase
    end

    // Stage p1: 2-entry output FIFO of {err, insn}
    logic [32:0] buf_p1_q [2];
    logic [32:0] head_p1;
    logic        wptr_q, rptr_q;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] insn_count_q, err_count_q;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign vld_p0    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign cnt_d     = cnt_q + {1'b0, vld_p0} - {1'b0, pop};
    assign head_p1   = buf_p1_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 2'd0;
            wptr_q       <= 1'b0;
            rptr_q       <= 1'b0;
            insn_count_q <= 16'd0;
            err_count_q  <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
            if (vld_p0) wptr_q <= ~wptr_q;
            if (pop) begin
                rptr_q       <= ~rptr_q;
                insn_count_q <= sat_inc(insn_count_q);
                if (head_p1[32]) err_count_q <= sat_inc(err_count_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0) buf_p1_q[wptr_q] <= {err_p0, insn_p0};
    end

    // Storage is not reset, so the head is masked while the buffer is empty.
    assign insn       = out_valid ? head_p1[31:0] : 32'd0;
    assign err        = out_valid & head_p1[32];
    assign insn_count = insn_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_insn_encode.sv
// Bench for insn_encode: directed encodings, backpressure, streaming, reset,
// and randomized traffic against an arithmetic reference model with round trip.
module tb_insn_encode;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, err;
    logic [4:0]  opcode, rd, rs1, rs2;
    logic [3:0]  alu_op;
    logic [31:0] imm, insn;
    logic [15:0] insn_count, err_count;

    insn_encode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .insn(insn), .err(err),
        .insn_count(insn_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } bundle_t;

    typedef struct packed {
        bundle_t     b;
        logic [31:0] w;
        logic        e;
    } entry_t;

    entry_t     exp_q[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         m_icnt = 0;
    int         m_ecnt = 0;
    logic [4:0] legal_ops [9] = '{5'b01100, 5'b11001, 5'b00000, 5'b00100, 5'b10000,
                                  5'b11000, 5'b01101, 5'b00101, 5'b11011};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [4:0] op, input logic [3:0] alu,
                                   input logic [4:0] d, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic [31:0] im);
        bundle_t b;
        b.op = op; b.alu = alu; b.rd = d; b.rs1 = s1; b.rs2 = s2; b.imm = im;
        return b;
    endfunction

    // Reference encoder: fields placed by arithmetic weight, ranges by signed bounds.
    function automatic entry_t model(input bundle_t b);
        entry_t      r;
        int          s;
        logic [2:0]  f3;
        logic [31:0] w, rdf, rs1f, rs2f;
        s    = $signed(b.imm);
        f3   = b.alu[2:0];
        rdf  = 32'(b.rd) << 7;
        rs1f = 32'(b.rs1) << 15;
        rs2f = 32'(b.rs2) << 20;
        w    = 32'(b.op) * 32'd4 + 32'd3;
        r.e  = 1'b0;
        case (b.op)
            5'b01100: w += rdf + (32'(f3) << 12) + rs1f + rs2f + (32'(b.alu[3]) << 30);
            5'b11001, 5'b00000, 5'b00100: begin
                if (b.op == 5'b11001) f3 = 3'd0;
                w += rdf + (32'(f3) << 12) + rs1f;
                if (b.op == 5'b00100 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w += ((b.imm % 32'd32) << 20) + (32'(b.alu[3]) << 30);
                    r.e = (s < 0) || (s > 31);
                end else begin
                    w += (b.imm % 32'd4096) << 20;
                    r.e = (s < -2048) || (s > 2047);
                end
            end
            5'b10000: begin
                w += (((b.imm / 32'd32) % 32'd128) << 25) + ((b.imm % 32'd32) << 7)
                   + (32'(f3) << 12) + rs1f + rs2f;
                r.e = (s < -2048) || (s > 2047);
            end
            5'b11000: begin
                w += (((b.imm >> 12) % 32'd2) << 31) + (((b.imm >> 5) % 32'd64) << 25)
                   + rs2f + rs1f + (32'(f3) << 12) + (((b.imm >> 1) % 32'd16) << 8)
                   + (((b.imm >> 11) % 32'd2) << 7);
                r.e = (s < -4096) || (s > 4095) || ((b.imm % 32'd2) != 32'd0);
            end
            5'b01101, 5'b00101: begin
                w += (b.imm / 32'd4096) * 32'd4096 + rdf;
                r.e = (b.imm % 32'd4096) != 32'd0;
            end
            5'b11011: begin
                w += (((b.imm >> 20) % 32'd2) << 31) + (((b.imm >> 1) % 32'd1024) << 21)
                   + (((b.imm >> 11) % 32'd2) << 20) + (((b.imm >> 12) % 32'd256) << 12) + rdf;
                r.e = (s < -1048576) || (s > 1048575) || ((b.imm % 32'd2) != 32'd0);
            end
            default: r.e = 1'b1;
        endcase
        r.b = b;
        r.w = w;
        return r;
    endfunction

    // Decode a legal word back into fields and compare with the source bundle.
    function automatic logic rt_ok(input bundle_t b, input logic [31:0] w);
        logic ok;
        ok = (w[6:2] == b.op) && (w[1:0] == 2'b11);
        case (b.op)
            5'b01100: ok = ok && w[11:7] == b.rd && w[19:15] == b.rs1 && w[24:20] == b.rs2
                          && w[14:12] == b.alu[2:0] && w[30] == b.alu[3];
            5'b11001, 5'b00000, 5'b00100: begin
                ok = ok && w[11:7] == b.rd && w[19:15] == b.rs1;
                if (b.op == 5'b00100 && (b.alu[2:0] == 3'd1 || b.alu[2:0] == 3'd5))
                    ok = ok && {27'd0, w[24:20]} == b.imm && w[30] == b.alu[3]
                            && w[14:12] == b.alu[2:0];
                else
                    ok = ok && {{20{w[31]}}, w[31:20]} == b.imm
                            && w[14:12] == ((b.op == 5'b11001) ? 3'd0 : b.alu[2:0]);
            end
            5'b10000: ok = ok && w[19:15] == b.rs1 && w[24:20] == b.rs2
                          && w[14:12] == b.alu[2:0]
                          && {{20{w[31]}}, w[31:25], w[11:7]} == b.imm;
            5'b11000: ok = ok && w[19:15] == b.rs1 && w[24:20] == b.rs2
                          && w[14:12] == b.alu[2:0]
                          && {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} == b.imm;
            5'b01101, 5'b00101: ok = ok && w[11:7] == b.rd && {w[31:12], 12'd0} == b.imm;
            5'b11011: ok = ok && w[11:7] == b.rd
                          && {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0} == b.imm;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.op  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 8)];
        b.alu = 4'($urandom);
        b.rd  = 5'($urandom);
        b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom);
        case ($urandom_range(0, 5))
            0: b.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: b.imm = 32'($urandom_range(0, 31));
            2: b.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            3: b.imm = $urandom & 32'hFFFFF000;
            4: b.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
            default: b.imm = $urandom;
        endcase
        return b;
    endfunction

    // One clock cycle: drive inputs, check outputs against the scoreboard, advance.
    task automatic drive_cycle(input logic v, input bundle_t b, input logic ordy);
        logic full;
        in_valid = v; opcode = b.op; alu_op = b.alu; rd = b.rd;
        rs1 = b.rs1; rs2 = b.rs2; imm = b.imm; out_ready = ordy;
        #1;
        full = (exp_q.size() == 2);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, !full});
        chk("insn_count", {16'd0, insn_count}, m_icnt);
        chk("err_count", {16'd0, err_count}, m_ecnt);
        if (exp_q.size() != 0) begin
            chk("head_insn", insn, exp_q[0].w);
            chk("head_err", {31'd0, err}, {31'd0, exp_q[0].e});
            if (ordy) begin
                if (!exp_q[0].e) chk("roundtrip", {31'd0, rt_ok(exp_q[0].b, insn)}, 32'd1);
                if (m_icnt < 65535) m_icnt++;
                if (exp_q[0].e && m_ecnt < 65535) m_ecnt++;
                void'(exp_q.pop_front());
            end
        end
        if (v && !full) exp_q.push_back(model(b));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_icnt = 0;
        m_ecnt = 0;
    endtask

    bundle_t b, nb;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; alu_op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        nb = mk(5'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_insn", insn, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_counts", {insn_count, err_count}, 32'd0);
        rst = 1'b0;

        b = mk(5'b00100, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        drive_cycle(1'b1, b, 1'b0);
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_insn", insn, 32'h00500093);
        chk("addi_err", {31'd0, err}, 32'd0);
        drive_cycle(1'b0, b, 1'b1);

        b = mk(5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0);
        drive_cycle(1'b1, b, 1'b0);
        chk("sub_insn", insn, 32'h402081B3);
        drive_cycle(1'b0, b, 1'b1);

        b = mk(5'b11000, 4'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        drive_cycle(1'b1, b, 1'b0);
        chk("beq_insn", insn, 32'hFE208EE3);
        chk("beq_err", {31'd0, err}, 32'd0);
        drive_cycle(1'b0, b, 1'b1);

        b = mk(5'b11011, 4'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        drive_cycle(1'b1, b, 1'b0);
        chk("jal_odd_err", {31'd0, err}, 32'd1);
        drive_cycle(1'b0, b, 1'b1);

        b = mk(5'b01101, 4'd0, 5'd1, 5'd0, 5'd0, 32'h12345001);
        drive_cycle(1'b1, b, 1'b0);
        chk("lui_err", {31'd0, err}, 32'd1);
        chk("lui_insn", insn, 32'h123450B7);
        drive_cycle(1'b0, b, 1'b1);

        b = mk(5'b00100, 4'b0001, 5'd2, 5'd3, 5'd0, 32'd32);
        drive_cycle(1'b1, b, 1'b0);
        chk("slli32_err", {31'd0, err}, 32'd1);
        drive_cycle(1'b0, b, 1'b1);

        b = mk(5'b11111, 4'hF, 5'd5, 5'd3, 5'd7, 32'hFFFFFFFF);
        drive_cycle(1'b1, b, 1'b0);
        chk("unsup_err", {31'd0, err}, 32'd1);
        chk("unsup_insn", insn, 32'h0000007F);
        drive_cycle(1'b0, b, 1'b1);
        chk("dir_err_count", {16'd0, err_count}, 32'd4);
        chk("dir_insn_count", {16'd0, insn_count}, 32'd7);

        // Backpressure: third bundle must be refused while full, even with out_ready high.
        drive_cycle(1'b1, mk(5'b00100, 4'd0, 5'd4, 5'd4, 5'd0, 32'd11), 1'b0);
        drive_cycle(1'b1, mk(5'b00100, 4'd0, 5'd5, 5'd5, 5'd0, 32'd22), 1'b0);
        chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        b = mk(5'b00100, 4'd0, 5'd6, 5'd6, 5'd0, 32'd33);
        drive_cycle(1'b1, b, 1'b0);
        repeat (3) drive_cycle(1'b0, b, 1'b0);
        chk("bp_stall_insn", insn, 32'h00B20213);
        drive_cycle(1'b1, b, 1'b1);
        drive_cycle(1'b1, b, 1'b1);
        repeat (3) drive_cycle(1'b0, b, 1'b1);

        // Streaming at one word per cycle.
        do_reset();
        for (int i = 0; i < 100; i++) drive_cycle(1'b1, rand_bundle(), 1'b1);
        drive_cycle(1'b0, nb, 1'b1);
        chk("stream_count", {16'd0, insn_count}, 32'd100);

        // Reset in the middle of a stream.
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, rand_bundle(), 1'b0);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete(); m_icnt = 0; m_ecnt = 0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_counts", {insn_count, err_count}, 32'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++)
            drive_cycle($urandom_range(0, 3) != 0, rand_bundle(), $urandom_range(0, 3) != 0);
        repeat (4) drive_cycle(1'b0, nb, 1'b1);
        chk("final_empty", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
